sar_search_ctrl: RTL and testbench

//  Operand-side controller for a magnitude comparator: finds an unknown WIDTH-bit target by binary search.

---
 rtl/sar_search_ctrl_if.sv | 25 ++
 rtl/sar_search_ctrl.sv | 136 +++++++++++++
 tb/tb_sar_search_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_ctrl_if.sv
// Handshake and comparator bundle between the sequencing FSM, the search controller and the comparator.
// The master side issues start and returns g/l/e; the slave side is the search controller.
interface sar_search_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             g;
  logic             l;
  logic             e;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, g, l, e,
    input  probe, busy, done, result, err
  );

  modport slave (
    input  start, g, l, e,
    output probe, busy, done, result, err
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Binary-search operand controller: steps the comparator's b operand until it reports equality,
// then returns the matched value (or an error when the g/l/e answers are inconsistent).
module sar_search_ctrl #(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sar_search_ctrl_if.slave    bus
);

  localparam int               WW      = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
  localparam logic [WW-1:0]    LAT     = WW'(CMP_LAT);
  localparam logic [WIDTH:0]   HI_INIT = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] P_INIT  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] P_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] P_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH:0]   r_lo, r_hi, w_lo_nxt, w_hi_nxt;
  logic [WIDTH-1:0] r_probe, r_result, w_probe_nxt, w_result_nxt;
  logic [WW-1:0]    r_wait, w_wait_nxt;
  logic             r_busy, r_done, r_err, w_busy_nxt, w_done_nxt, w_err_nxt;

  logic             w_onehot;
  logic [WIDTH:0]   w_lo_g, w_hi_l, w_nlo, w_nhi;
  logic [WIDTH+1:0] w_nsum;
  logic             w_bad_bounds;
  logic             w_edge_hit;

  assign w_onehot = ({bus.g, bus.l, bus.e} == 3'b100) ||
                    ({bus.g, bus.l, bus.e} == 3'b010) ||
                    ({bus.g, bus.l, bus.e} == 3'b001);

  // Candidate bounds for a g or l answer; only used once the range-edge cases are excluded.
  assign w_lo_g       = {1'b0, r_probe} + (WIDTH+1)'(1);
  assign w_hi_l       = {1'b0, r_probe} - (WIDTH+1)'(1);
  assign w_nlo        = bus.g ? w_lo_g : r_lo;
  assign w_nhi        = bus.g ? r_hi : w_hi_l;
  assign w_nsum       = {1'b0, w_nlo} + {1'b0, w_nhi};
  assign w_bad_bounds = (w_nlo > w_nhi);
  assign w_edge_hit   = (bus.g && (r_probe == P_MAX)) || (bus.l && (r_probe == P_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_probe  <= '0;
      r_wait   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_probe  <= w_probe_nxt;
      r_wait   <= w_wait_nxt;
      r_result <= w_result_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_probe_nxt  = r_probe;
    w_wait_nxt   = r_wait;
    w_result_nxt = r_result;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_lo_nxt     = '0;
          w_hi_nxt     = HI_INIT;
          w_probe_nxt  = P_INIT;
          w_wait_nxt   = LAT;
          w_busy_nxt   = 1'b1;
          w_result_nxt = '0;
          w_err_nxt    = 1'b0;
          w_state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (r_wait != '0) begin
          w_wait_nxt = r_wait - WW'(1);
        end else if (!w_onehot || bus.e) begin
          w_result_nxt = r_probe;
          w_err_nxt    = !w_onehot;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = FIN;
        end else if (w_edge_hit || w_bad_bounds) begin
          // Comparator answers contradict the remaining range; report where it broke.
          w_result_nxt = r_probe;
          w_err_nxt    = 1'b1;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = FIN;
        end else begin
          w_lo_nxt    = w_nlo;
          w_hi_nxt    = w_nhi;
          w_probe_nxt = w_nsum[WIDTH:1];
          w_wait_nxt  = LAT;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.probe  = r_probe;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl with a registered one-cycle comparator model.
module tb_sar_search_ctrl;

  logic clk;
  logic rst_n;
  int   target;
  int   cmp_mode;
  int   checks;
  int   errors;

  typedef struct {
    int          res;
    int          er;
    int          lat;
    int          ntr;
    logic [31:0] tr;
  } exp_t;

  exp_t sb[$];

  sar_search_ctrl_if #(.WIDTH(4)) bus ();

  sar_search_ctrl #(.WIDTH(4), .CMP_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator: 0 honest, 1 g=l=1, 2 target is target+0.5, 3 always g, 4 always l.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.g <= 1'b0;
      bus.l <= 1'b0;
      bus.e <= 1'b0;
    end else begin
      case (cmp_mode)
        0: begin
          bus.g <= (target > int'(bus.probe));
          bus.l <= (target < int'(bus.probe));
          bus.e <= (target == int'(bus.probe));
        end
        1: begin bus.g <= 1'b1; bus.l <= 1'b1; bus.e <= 1'b0; end
        2: begin
          bus.g <= ((2 * target + 1) > (2 * int'(bus.probe)));
          bus.l <= ((2 * target + 1) < (2 * int'(bus.probe)));
          bus.e <= 1'b0;
        end
        3: begin bus.g <= 1'b1; bus.l <= 1'b0; bus.e <= 1'b0; end
        default: begin bus.g <= 1'b0; bus.l <= 1'b1; bus.e <= 1'b0; end
      endcase
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int iters(input int a);
    int lo, hi, p, n;
    lo = 0; hi = 15; n = 0;
    for (int k = 0; k < 8; k++) begin
      p = (lo + hi) / 2;
      n++;
      if (p == a) return n;
      if (a > p) lo = p + 1;
      else hi = p - 1;
    end
    return n;
  endfunction

  // Monitor: collects probe trace and busy length, checks each done against the scoreboard.
  int          m_lat;
  int          m_ntr;
  logic [31:0] m_tr;
  logic        m_prev_busy;

  always @(negedge clk or negedge rst_n) begin
    exp_t x;
    if (!rst_n) begin
      m_lat = 0;
      m_ntr = 0;
      m_tr = '0;
      m_prev_busy = 1'b0;
    end else if (!clk) begin
      if (bus.busy) begin
        if (!m_prev_busy) begin
          m_lat = 1; m_ntr = 0; m_tr = '0;
        end else begin
          m_lat++;
        end
        if (m_ntr == 0 || m_tr[4*(m_ntr-1) +: 4] != bus.probe) begin
          if (m_ntr < 8) m_tr[4*m_ntr +: 4] = bus.probe;
          m_ntr++;
        end
      end
      if (bus.done) begin
        chk("busy_at_done", int'(bus.busy), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("result", int'(bus.result), x.res);
          chk("err", int'(bus.err), x.er);
          chk("latency", m_lat, x.lat);
          if (x.ntr > 0) begin
            chk("probe_count", m_ntr, x.ntr);
            chk("probe_trace", int'(m_tr), int'(x.tr));
          end
        end
      end
      m_prev_busy = bus.busy;
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle after done.
  task automatic run(input int a, input int mode, input int res, input int er, input int lat,
                     input int ntr, input logic [31:0] tr, input int glitch, input bit fin_start);
    bit seen;
    exp_t x;
    target = a;
    cmp_mode = mode;
    x.res = res; x.er = er; x.lat = lat; x.ntr = ntr; x.tr = tr;
    sb.push_back(x);
    bus.start = 1'b1;
    @(negedge clk);
    seen = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      bus.start = (i == glitch);
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    bus.start = fin_start;
    @(negedge clk);
    bus.start = 1'b0;
    if (fin_start) chk("start_in_fin_busy", int'(bus.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    target = 0;
    cmp_mode = 0;
    bus.start = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_probe", int'(bus.probe), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(7,  0, 7,  0, 2,  1, 32'h0000_0007, 0, 1'b0);
    run(15, 0, 15, 0, 10, 5, 32'h000F_EDB7, 0, 1'b0);
    run(0,  0, 0,  0, 8,  4, 32'h0000_0137, 0, 1'b0);
    run(0,  1, 7,  1, 2,  1, 32'h0000_0007, 0, 1'b0);
    run(0,  3, 15, 1, 10, 5, 32'h000F_EDB7, 0, 1'b0);
    run(0,  4, 0,  1, 8,  4, 32'h0000_0137, 0, 1'b0);
    run(7,  2, 8,  1, 8,  4, 32'h0000_89B7, 0, 1'b0);
    run(5,  0, 5,  0, 6,  3, 32'h0000_0537, 3, 1'b1);

    for (int a = 0; a < 16; a++) run(a, 0, a, 0, 2 * iters(a), 0, '0, 0, 1'b0);

    target = 15;
    cmp_mode = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_probe", int'(bus.probe), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_result", int'(bus.result), 0);
    chk("abort_err", int'(bus.err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run(9, 0, 9, 0, 6, 3, 32'h0000_09B7, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
